data_compare_seq: RTL and testbench
===================================

# data_compare_seq

Parametrised sequential magnitude comparator: compares two WIDTH-bit operands over multiple cycles, SLICE bits per cycle MSB-first, with cascade input for chaining. It is the multi-width, handshaked successor of the 4-bit combinational comparator in the datapath compare unit. It returns the same one-hot GT/LT/EQ code, and handshakes operands in and results out so it can sit between pipeline stages.

## Interface
- WIDTH, 16, operand width; must be a multiple of SLICE, else elaboration error
- SLICE, 4, bits compared per cycle; N = WIDTH/SLICE slice steps (N ≥ 1)
- SIGNED, 0, 1 = operands are two's complement
- iClk  in  1  clock, all logic on rising edge
- iRst  in  1  reset, synchronous, active-high
- iValid  in  1  operand valid
- oReady  out  1  block accepts operands
- iData_a  in  WIDTH  operand a
- iData_b  in  WIDTH  operand b
- iData  in  3  cascade code from a lower-order stage: 100 a>b, 010 a<b, 001 a=b
- oValid  out  1  result valid
- iReady  in  1  downstream accepts result
- oData  out  3  result: 100 A>B, 010 A<B, 001 A=B

## Operation
- States: IDLE, RUN, DONE.
- IDLE: oReady=1. On iValid=1, capture a, b, cascade; slice index ← N-1 (MSB slice); go to RUN.
- RUN: oReady=0. Compare captured slice[index]; slice index decrements by 1 per cycle.
  - Bit SLICE-1 of the top slice is inverted on both operands when SIGNED=1.
  - The first differing slice fixes the result: 100 or 010. Later slices cannot change it.
  - After slice 0, or an early exit (see Configuration), go to DONE.
  - If all slices are equal, result = cascade code. A non-one-hot cascade code (anything other than 100/010/001) yields 001.
- DONE: oValid=1, oData = result held stable. On iReady=1, go to IDLE; oValid=0 next cycle.
- iValid is ignored outside IDLE. Operand inputs may change freely after capture.
- Back-to-back: IDLE after DONE lasts at least one cycle. No operand accept in the same cycle as the result handoff.

## Timing
- Reset values: state IDLE, oValid=0, oData=3'b000, oReady=0 while iRst=1, then 1 from the first cycle after reset deasserts.
- Accept edge = cycle 0. Full scan: RUN occupies cycles 1..N, and oValid is high from cycle N+1.
- Early exit: oValid is high in cycle k+1, where k = number of slices examined (1..N).
- Throughput without early exit: one compare per N+2 cycles with iReady held at 1.
- Reset mid-RUN or mid-DONE aborts the operation: oValid=0 at the next edge and no result is emitted.
- iReady may be high before DONE. It has no effect until oValid=1.

## Configuration
- DATA_COMPARE_EARLY_EXIT_EN defined: RUN goes to DONE in the same cycle the first differing slice is seen.
- Not defined: RUN always scans all N slices. Latency is fixed at N, and the result stays frozen after the first difference.

## Structure
- Shared package data_compare_pkg:
  - Code constants CMP_GT=3'b100, CMP_LT=3'b010, CMP_EQ=3'b001.
  - State enum (IDLE/RUN/DONE).
- Sub-module data_compare_slice: combinational SLICE-bit compare of one slice pair, with a per-instance sign-invert input. Outputs gt/lt.
- The top module holds the FSM, operand registers, slice index counter ($clog2(N), minimum 1 bit), and result register.

## Test plan
All cases use WIDTH=16, SLICE=4 unless stated.
- a=16'h1234, b=16'h1234, cascade 100 → oData=100 with oValid at cycle 5; same operands with cascade 001 → 001.
- SIGNED=0, a=16'h8000, b=16'h7FFF → oData=100. oValid at cycle 2 with DATA_COMPARE_EARLY_EXIT_EN, cycle 5 without.
- SIGNED=1, a=16'h8000, b=16'h7FFF → oData=010. Also a=16'hFFFF, b=16'hFFFE → 100.
- a=16'h00A1, b=16'h00A2, iReady low 6 cycles in DONE → oData=010 stable, oValid=1, oReady=0; iValid pulses are ignored.
- iRst pulsed in RUN cycle 2 → oValid never rises. The cycle after iRst deasserts: oReady=1, oData=000.
- Equal operands, cascade 3'b011 → oData=001.

Source files
------------

// File: rtl/data_compare_pkg.sv
// Shared result codes, FSM state type and cascade helper for the sequential comparator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_compare_pkg;

  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_LT   = 3'b010;
  localparam logic [2:0] CMP_EQ   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  // A malformed cascade code from a lower stage is treated as "equal".
  function automatic logic [2:0] cmp_cascade_norm(input logic [2:0] code);
    logic [2:0] res;
    res = CMP_EQ;
    if ((code == CMP_GT) || (code == CMP_LT) || (code == CMP_EQ)) begin
      res = code;
    end
    return res;
  endfunction

endpackage

// File: rtl/data_compare_slice.sv
// Combinational magnitude compare of one SLICE-bit slice pair, optional sign-bit flip.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle.
module data_compare_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_sl,
  input  logic [SLICE-1:0] b_sl,
  input  logic             inv_msb,
  output logic             gt,
  output logic             lt
);

  logic [SLICE-1:0] a_m;
  logic [SLICE-1:0] b_m;

  // Flipping the sign bit makes two's complement order the same as unsigned order.
  always_comb begin
    a_m          = a_sl;
    b_m          = b_sl;
    a_m[SLICE-1] = a_sl[SLICE-1] ^ inv_msb;
    b_m[SLICE-1] = b_sl[SLICE-1] ^ inv_msb;
    gt           = (a_m > b_m);
    lt           = (a_m < b_m);
  end

endmodule

// File: rtl/data_compare_seq.sv
// Sequential WIDTH-bit magnitude compare, SLICE bits per cycle MSB-first, one-hot GT/LT/EQ result.
// Latency: N = WIDTH/SLICE RUN cycles (fewer with DATA_COMPARE_EARLY_EXIT_EN), result valid the cycle after.
// Backpressure: result held in DONE until iReady; oReady low from accept until the handoff completes.
// Optional build macro: DATA_COMPARE_EARLY_EXIT_EN ends the scan on the first differing slice.
module data_compare_seq #(
  parameter int WIDTH  = 16,
  parameter int SLICE  = 4,
  parameter int SIGNED = 0
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic [2:0]       iData,
  output logic             oValid,
  input  logic             iReady,
  output logic [2:0]       oData
);

  import data_compare_pkg::*;

  localparam int                 N       = WIDTH / SLICE;
  localparam int                 IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0]   TOP_IDX = IDX_W'(N - 1);

`ifdef DATA_COMPARE_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  if ((SLICE < 1) || (WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
    $error("data_compare_seq: WIDTH must be a positive multiple of SLICE");
  end

  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       casc_q, casc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       diff_q, diff_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [2:0]       data_q, data_d;

  logic             sl_gt;
  logic             sl_lt;
  logic             sl_inv;
  logic             hit;
  logic             last;

  // Operands are shifted left each RUN cycle, so the slice under test is always the top one.
  assign sl_inv = (SIGNED != 0) && (idx_q == TOP_IDX);

  data_compare_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a_sl    (a_q[WIDTH-1 -: SLICE]),
    .b_sl    (b_q[WIDTH-1 -: SLICE]),
    .inv_msb (sl_inv),
    .gt      (sl_gt),
    .lt      (sl_lt)
  );

  // Next-state logic: accept in IDLE, scan one slice per RUN cycle, hold the result in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    casc_d  = casc_q;
    idx_d   = idx_q;
    diff_d  = diff_q;
    valid_d = valid_q;
    ready_d = ready_q;
    data_d  = data_q;
    hit     = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // ready_q is low only for the first cycle out of reset; it rises here.
        ready_d = 1'b1;
        if (iValid && ready_q) begin
          a_d     = iData_a;
          b_d     = iData_b;
          casc_d  = iData;
          idx_d   = TOP_IDX;
          diff_d  = CMP_NONE;
          ready_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Only the first differing slice may set the verdict; later slices are ignored.
        hit = (diff_q == CMP_NONE) && (sl_gt || sl_lt);
        if (hit) begin
          diff_d = sl_gt ? CMP_GT : CMP_LT;
        end
        last  = (idx_q == '0) || (EARLY_EXIT && hit);
        a_d   = a_q << SLICE;
        b_d   = b_q << SLICE;
        idx_d = idx_q - 1'b1;
        if (last) begin
          state_d = DONE;
          valid_d = 1'b1;
          data_d  = (diff_d != CMP_NONE) ? diff_d : cmp_cascade_norm(casc_q);
        end
      end
      DONE: begin
        if (iReady) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      casc_q  <= CMP_NONE;
      idx_q   <= '0;
      diff_q  <= CMP_NONE;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= CMP_NONE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      casc_q  <= casc_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  assign oReady = ready_q;
  assign oValid = valid_q;
  assign oData  = data_q;

endmodule

// File: tb/tb_data_compare_seq.sv
// Bench for data_compare_seq: unsigned and signed instances share all inputs.
// A timeline model predicts handshake and result per cycle; directed vectors pin literal values.
// Honours DATA_COMPARE_EARLY_EXIT_EN when predicting latency.
module tb_data_compare_seq;

  localparam int W = 16;
  localparam int S = 4;
  localparam int N = W / S;

`ifdef DATA_COMPARE_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic          iClk    = 1'b0;
  logic          iRst    = 1'b1;
  logic          iValid  = 1'b0;
  logic          iReady  = 1'b0;
  logic [W-1:0]  iData_a = '0;
  logic [W-1:0]  iData_b = '0;
  logic [2:0]    iData   = 3'b001;

  logic          oReady_u, oValid_u;
  logic [2:0]    oData_u;
  logic          oReady_s, oValid_s;
  logic [2:0]    oData_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 iClk = ~iClk;

  data_compare_seq #(.WIDTH(W), .SLICE(S), .SIGNED(0)) u_dut_u (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady_u),
    .iData_a(iData_a), .iData_b(iData_b), .iData(iData),
    .oValid(oValid_u), .iReady(iReady), .oData(oData_u)
  );

  data_compare_seq #(.WIDTH(W), .SLICE(S), .SIGNED(1)) u_dut_s (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady_s),
    .iData_a(iData_a), .iData_b(iData_b), .iData(iData),
    .oValid(oValid_s), .iReady(iReady), .oData(oData_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected code straight from the arithmetic comparison of the full operands.
  function automatic logic [2:0] exp_code(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] c, input bit sgn);
    if (sgn) begin
      if ($signed(a) > $signed(b)) return 3'b100;
      if ($signed(a) < $signed(b)) return 3'b010;
    end else begin
      if (a > b) return 3'b100;
      if (a < b) return 3'b010;
    end
    if ((c == 3'b100) || (c == 3'b010) || (c == 3'b001)) return c;
    return 3'b001;
  endfunction

  // Slices examined before the result is known.
  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    if (!EE) return N;
    for (int s = 0; s < N; s++) begin
      if (((a >> (W - S * (s + 1))) & 16'hF) != ((b >> (W - S * (s + 1))) & 16'hF)) return s + 1;
    end
    return N;
  endfunction

  // Timeline model: ready/valid/result expected after each rising edge.
  int         cyc       = 0;
  int         m_due     = 0;
  logic       m_started = 1'b0;
  logic       m_rdy     = 1'b0;
  logic       m_vld     = 1'b0;
  logic       m_busy    = 1'b0;
  logic [2:0] m_res_u   = 3'b000;
  logic [2:0] m_res_s   = 3'b000;
  logic [2:0] m_dat_u   = 3'b000;
  logic [2:0] m_dat_s   = 3'b000;

  always @(posedge iClk) begin
    cyc       <= cyc + 1;
    m_started <= 1'b1;
    if (iRst) begin
      m_rdy  <= 1'b0;
      m_vld  <= 1'b0;
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (m_rdy && iValid) begin
        m_busy  <= 1'b1;
        m_rdy   <= 1'b0;
        m_due   <= cyc + exp_lat(iData_a, iData_b);
        m_res_u <= exp_code(iData_a, iData_b, iData, 1'b0);
        m_res_s <= exp_code(iData_a, iData_b, iData, 1'b1);
      end else begin
        m_rdy <= 1'b1;
      end
    end else if (!m_vld) begin
      if (cyc == m_due) begin
        m_vld   <= 1'b1;
        m_dat_u <= m_res_u;
        m_dat_s <= m_res_s;
      end
    end else if (iReady) begin
      m_vld  <= 1'b0;
      m_busy <= 1'b0;
      m_rdy  <= 1'b1;
    end
  end

  always @(negedge iClk) begin
    if (m_started) begin
      chk("oValid_u", oValid_u, m_vld);
      chk("oValid_s", oValid_s, m_vld);
      chk("oReady_u", oReady_u, m_rdy);
      chk("oReady_s", oReady_s, m_rdy);
      if (m_vld) begin
        chk("oData_u", oData_u, m_dat_u);
        chk("oData_s", oData_s, m_dat_s);
      end
    end
  end

  // One compare; hold = cycles to stall in DONE (0 = iReady raised before DONE).
  task automatic run_cmp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] c, input logic [2:0] eu, input logic [2:0] es,
                         input int ecyc, input int hold);
    int t;
    @(negedge iClk);
    iData_a = a;
    iData_b = b;
    iData   = c;
    iValid  = 1'b1;
    iReady  = (hold == 0);
    t = 0;
    while (!oReady_u && t < 20) begin
      @(negedge iClk);
      t++;
    end
    chk({tag, "_accept"}, (t < 20), 1);
    @(posedge iClk);
    @(negedge iClk);
    iValid  = 1'b0;
    iData_a = ~a;
    iData_b = ~b;
    iData   = 3'b111;
    t = 1;
    while (!oValid_u && t < 40) begin
      @(negedge iClk);
      t++;
      iValid = (t == 2);
    end
    iValid = 1'b0;
    chk({tag, "_cycle"}, t, ecyc);
    chk({tag, "_u"}, oData_u, eu);
    chk({tag, "_s"}, oData_s, es);
    for (int i = 0; i < hold; i++) begin
      iValid = i[0];
      @(negedge iClk);
      chk({tag, "_hold_vld"}, oValid_u, 1);
      chk({tag, "_hold_rdy"}, oReady_u, 0);
      chk({tag, "_hold_dat"}, oData_u, eu);
    end
    iValid = 1'b0;
    iReady = 1'b1;
    @(negedge iClk);
    chk({tag, "_post_vld"}, oValid_u, 0);
    chk({tag, "_post_rdy"}, oReady_u, 1);
    iReady = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic seen;
    repeat (2) @(negedge iClk);
    chk("rst_vld_u", oValid_u, 0);
    chk("rst_rdy_u", oReady_u, 0);
    chk("rst_dat_u", oData_u, 3'b000);
    chk("rst_dat_s", oData_s, 3'b000);
    iRst = 1'b0;
    @(negedge iClk);
    chk("rst_exit_rdy", oReady_u, 1);

    run_cmp("eq_casc_gt", 16'h1234, 16'h1234, 3'b100, 3'b100, 3'b100, 5, 0);
    run_cmp("eq_casc_eq", 16'h1234, 16'h1234, 3'b001, 3'b001, 3'b001, 5, 2);
    run_cmp("msb_8000",   16'h8000, 16'h7FFF, 3'b001, 3'b100, 3'b010, EE ? 2 : 5, 0);
    run_cmp("ffff_fffe",  16'hFFFF, 16'hFFFE, 3'b001, 3'b100, 3'b100, 5, 1);
    run_cmp("a1_a2_hold", 16'h00A1, 16'h00A2, 3'b100, 3'b010, 3'b010, 5, 6);
    run_cmp("casc_011",   16'h5A5A, 16'h5A5A, 3'b011, 3'b001, 3'b001, 5, 0);
    run_cmp("casc_000",   16'h5A5A, 16'h5A5A, 3'b000, 3'b001, 3'b001, 5, 0);
    run_cmp("casc_lt",    16'h5A5A, 16'h5A5A, 3'b010, 3'b010, 3'b010, 5, 1);
    run_cmp("freeze",     16'h2100, 16'h1F00, 3'b010, 3'b100, 3'b100, EE ? 2 : 5, 0);
    run_cmp("lsb_diff",   16'h1235, 16'h1234, 3'b010, 3'b100, 3'b100, 5, 0);

    // Reset asserted during RUN cycle 2 must drop the operation.
    @(negedge iClk);
    iData_a = 16'h0001;
    iData_b = 16'h0002;
    iData   = 3'b001;
    iValid  = 1'b1;
    t = 0;
    while (!oReady_u && t < 20) begin
      @(negedge iClk);
      t++;
    end
    chk("rst_run_accept", (t < 20), 1);
    @(posedge iClk);
    @(negedge iClk);
    iValid = 1'b0;
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    chk("rst_run_vld", oValid_u, 0);
    @(negedge iClk);
    chk("rst_run_rdy_u", oReady_u, 1);
    chk("rst_run_rdy_s", oReady_s, 1);
    chk("rst_run_dat_u", oData_u, 3'b000);
    chk("rst_run_dat_s", oData_s, 3'b000);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge iClk);
      seen = seen | oValid_u | oValid_s;
    end
    chk("rst_run_no_result", seen, 0);

    run_cmp("after_rst",  16'h0000, 16'hFFFF, 3'b001, 3'b010, 3'b100, EE ? 2 : 5, 0);

    repeat (2) @(negedge iClk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
